golay_codec: RTL and testbench

// Extended binary Golay (24,12,8) FEC codec for the wb_fec path: encoder maps a
// 12-bit payload to 12 parity bits; decoder takes a 24-bit {payload,parity} word,

---
 rtl/golay_codec.sv | 126 ++++++++++++
 tb/tb_golay_codec.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/golay_codec.sv
// Extended binary Golay (24,12,8) codec: one-cycle encoder, two-stage decoder
// that corrects up to three errors and flags four-error words.
module golay_codec (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enc_stb_i,
    input  logic [11:0] enc_payload_i,
    output logic [11:0] enc_parity_o,
    input  logic        dec_stb_i,
    input  logic [23:0] dec_paycode_i,
    output logic        dec_decoded_o,
    output logic        dec_failed_o,
    output logic [11:0] dec_payload_o
);

    // Row k of B sits at bits [143-12k -: 12]; position k of a vector is bit 11-k.
    localparam logic [143:0] B_ROWS = 144'hDC5_B8B_717_E2D_C5B_8B7_16F_2DD_5B9_B71_6E3_FFE;

    function automatic logic [11:0] b_row(input int unsigned k);
        return B_ROWS[143 - 12*k -: 12];
    endfunction

    function automatic logic [11:0] unit_vec(input int unsigned k);
        return 12'h800 >> k;
    endfunction

    function automatic logic [11:0] mul_b(input logic [11:0] v);
        logic [11:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (v[11 - k]) acc = acc ^ b_row(k);
        end
        return acc;
    endfunction

    function automatic logic [3:0] wt(input logic [11:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    logic [11:0] r_enc_parity;
    logic [11:0] r_m;
    logic [11:0] r_s;
    logic [11:0] r_t;
    logic        r_v;
    logic        r_dec_decoded;
    logic        r_dec_failed;
    logic [11:0] r_dec_payload;

    logic [11:0] w_s;
    logic [11:0] w_em;
    logic        w_hit;

    assign w_s = mul_b(dec_paycode_i[23:12]) ^ dec_paycode_i[11:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_enc_parity <= '0;
        end else if (enc_stb_i) begin
            r_enc_parity <= mul_b(enc_payload_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_v <= 1'b0;
            r_m <= '0;
            r_s <= '0;
            r_t <= '0;
        end else begin
            r_v <= dec_stb_i;
            if (dec_stb_i) begin
                r_m <= dec_paycode_i[23:12];
                r_s <= w_s;
                r_t <= mul_b(w_s);
            end
        end
    end

    // Priority search over the four error classes; w_hit blocks later matches.
    always_comb begin
        w_em  = '0;
        w_hit = 1'b0;
        if (wt(r_s) <= 4'd3) w_hit = 1'b1;
        for (int unsigned k = 0; k < 12; k++) begin
            if (!w_hit && wt(r_s ^ b_row(k)) <= 4'd2) begin
                w_em  = unit_vec(k);
                w_hit = 1'b1;
            end
        end
        if (!w_hit && wt(r_t) <= 4'd3) begin
            w_em  = r_t;
            w_hit = 1'b1;
        end
        for (int unsigned k = 0; k < 12; k++) begin
            if (!w_hit && wt(r_t ^ b_row(k)) <= 4'd2) begin
                w_em  = r_t ^ b_row(k);
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dec_decoded <= 1'b0;
            r_dec_failed  <= 1'b0;
            r_dec_payload <= '0;
        end else begin
            r_dec_decoded <= r_v;
            if (r_v) begin
                r_dec_failed  <= ~w_hit;
                r_dec_payload <= r_m ^ w_em;
            end
        end
    end

    assign enc_parity_o  = r_enc_parity;
    assign dec_decoded_o = r_dec_decoded;
    assign dec_failed_o  = r_dec_failed;
    assign dec_payload_o = r_dec_payload;

endmodule

// File: tb/tb_golay_codec.sv
// Directed and streaming checks for golay_codec: encoder vectors, decoder
// correction/failure cases, back-to-back exhaustive stream, mid-flight reset.
module tb_golay_codec;

    logic        clk;
    logic        rst_n;
    logic        enc_stb;
    logic [11:0] enc_payload;
    logic [11:0] enc_parity;
    logic        dec_stb;
    logic [23:0] dec_paycode;
    logic        dec_decoded;
    logic        dec_failed;
    logic [11:0] dec_payload;

    int n_checks = 0;
    int n_errors = 0;

    golay_codec dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enc_stb_i     (enc_stb),
        .enc_payload_i (enc_payload),
        .enc_parity_o  (enc_parity),
        .dec_stb_i     (dec_stb),
        .dec_paycode_i (dec_paycode),
        .dec_decoded_o (dec_decoded),
        .dec_failed_o  (dec_failed),
        .dec_payload_o (dec_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] b_tab [12] = '{12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
                                12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE};

    function automatic logic [11:0] ref_mul(input logic [11:0] v);
        logic [11:0] acc;
        acc = '0;
        for (int k = 0; k < 12; k++) if (v[11 - k]) acc ^= b_tab[k];
        return acc;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic enc_vec(input string tag, input logic [11:0] pay, input logic [11:0] par);
        @(negedge clk);
        enc_stb = 1'b1;
        enc_payload = pay;
        @(posedge clk); #1;
        check_value(tag, {20'd0, enc_parity}, {20'd0, par});
        @(negedge clk);
        enc_stb = 1'b0;
        enc_payload = ~pay;
        @(posedge clk); #1;
        check_value({tag, "_hold"}, {20'd0, enc_parity}, {20'd0, par});
    endtask

    task automatic dec_vec(input string tag, input logic [23:0] word,
                           input logic [11:0] pay, input logic fail);
        @(negedge clk);
        dec_stb = 1'b1;
        dec_paycode = word;
        @(posedge clk); #1;
        check_value({tag, "_lat1"}, {31'd0, dec_decoded}, 32'd0);
        @(negedge clk);
        dec_stb = 1'b0;
        dec_paycode = '0;
        @(posedge clk); #1;
        check_value(tag, {18'd0, dec_decoded, dec_failed, dec_payload}, {18'd0, 1'b1, fail, pay});
        @(posedge clk); #1;
        check_value({tag, "_hold"}, {18'd0, dec_decoded, dec_failed, dec_payload}, {18'd0, 1'b0, fail, pay});
    endtask

    initial begin
        logic [11:0] pl;
        logic [11:0] prev;
        logic [23:0] e;
        int          nflip;

        rst_n = 1'b0;
        enc_stb = 1'b0;
        enc_payload = '0;
        dec_stb = 1'b0;
        dec_paycode = '0;
        prev = '0;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_out", {7'd0, enc_parity, dec_decoded, dec_failed, dec_payload}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        enc_vec("enc_800", 12'h800, 12'hDC5);
        enc_vec("enc_001", 12'h001, 12'hFFE);
        enc_vec("enc_FFF", 12'hFFF, 12'hFFF);
        enc_vec("enc_000", 12'h000, 12'h000);

        dec_vec("dec_clean",  24'h800DC5,            12'h800, 1'b0);
        dec_vec("dec_par3",   24'h800DC5 ^ 24'h000007, 12'h800, 1'b0);
        dec_vec("dec_pay3",   24'h800DC5 ^ 24'h700000, 12'h800, 1'b0);
        dec_vec("dec_mixed",  24'h800DC5 ^ 24'h400003, 12'h800, 1'b0);
        dec_vec("dec_4par",   24'h00000F,            12'h000, 1'b1);
        dec_vec("dec_4pay",   24'hF00000,            12'hF00, 1'b1);

        // Streamed: item i strobed before edge i, encoder result after edge i, decoder after edge i+1.
        for (int i = 0; i <= 4096; i++) begin
            @(negedge clk);
            if (i < 4096) begin
                pl = i[11:0];
                nflip = $urandom_range(3, 0);
                e = '0;
                while ($countones(e) < nflip) e = e | (24'h1 << $urandom_range(23, 0));
                enc_stb = 1'b1;
                enc_payload = pl;
                dec_stb = 1'b1;
                dec_paycode = {pl, ref_mul(pl)} ^ e;
            end else begin
                enc_stb = 1'b0;
                dec_stb = 1'b0;
                dec_paycode = '0;
            end
            @(posedge clk); #1;
            if (i < 4096) check_value("str_enc", {20'd0, enc_parity}, {20'd0, ref_mul(pl)});
            if (i >= 1) check_value("str_dec", {18'd0, dec_decoded, dec_failed, dec_payload},
                                    {18'd0, 1'b1, 1'b0, prev});
            prev = pl;
        end
        @(posedge clk); #1;
        check_value("str_end", {31'd0, dec_decoded}, 32'd0);

        // Reset while a decode is between stage 1 and stage 2.
        dec_vec("pre_rst", 24'hF00000, 12'hF00, 1'b1);
        @(negedge clk);
        dec_stb = 1'b1;
        dec_paycode = 24'h800DC5;
        @(posedge clk); #1;
        dec_stb = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("rst_mid", {7'd0, enc_parity, dec_decoded, dec_failed, dec_payload}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_value("rst_nopulse", {18'd0, dec_decoded, dec_failed, dec_payload}, 32'd0);
        @(posedge clk); #1;
        check_value("rst_nopulse2", {31'd0, dec_decoded}, 32'd0);
        dec_vec("post_rst", 24'h800DC5 ^ 24'h000007, 12'h800, 1'b0);
        enc_vec("post_rst_enc", 12'h800, 12'hDC5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
